// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared types and constants for the ALU arbiter slice: FSM state encoding,
// requester count, flag bit positions and the ALU opcode map.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_arb_pkg;

   localparam int NUM_REQ = 2;

   // Bit positions inside the 4-bit {N, Z, C, V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // ALU opcodes
   localparam logic [3:0] ALU_OP_ADD = 4'd0;
   localparam logic [3:0] ALU_OP_SUB = 4'd1;
   localparam logic [3:0] ALU_OP_AND = 4'd2;
   localparam logic [3:0] ALU_OP_OR  = 4'd3;
   localparam logic [3:0] ALU_OP_XOR = 4'd4;
   localparam logic [3:0] ALU_OP_SLL = 4'd5;
   localparam logic [3:0] ALU_OP_SRL = 4'd6;
   localparam logic [3:0] ALU_OP_SRA = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Request/response bundle between the two requesters and the ALU arbiter.
//   req_valid/req_ready [1:0]   per-requester request handshake
//   req_a/req_b [1:0][31:0]     operands per requester
//   req_op [1:0][3:0]           ALU opcode per requester
//   resp_valid/resp_ready [1:0] one-hot response handshake
//   resp_res [31:0]             captured ALU result
//   resp_flags [3:0]            captured flags {N, Z, C, V}
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface alu_arbiter_if;
   import alu_arb_pkg::*;

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0][31:0] req_a;
   logic [NUM_REQ-1:0][31:0] req_b;
   logic [NUM_REQ-1:0][3:0]  req_op;
   logic [NUM_REQ-1:0]       resp_valid;
   logic [NUM_REQ-1:0]       resp_ready;
   logic [31:0]              resp_res;
   logic [3:0]               resp_flags;

   modport master (
      output req_valid, req_a, req_b, req_op, resp_ready,
      input  req_ready, resp_valid, resp_res, resp_flags
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, resp_ready,
      output req_ready, resp_valid, resp_res, resp_flags
   );

endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU.
//   a, b  [31:0]  operands
//   op    [3:0]   opcode (see alu_arb_pkg)
//   res   [31:0]  result
//   flags [3:0]   {N, Z, C, V}; C is carry-out for add and no-borrow for sub,
//                 C and V are 0 for logic and shift operations.
// -----------------------------------------------------------------------------
module alu
   import alu_arb_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   output logic [31:0] res,
   output logic [3:0]  flags
);

   logic [32:0] sum;
   logic [31:0] r;
   logic        carry;
   logic        ovf;

   always_comb begin
      sum   = '0;
      r     = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (op)
         ALU_OP_ADD: begin
            sum   = {1'b0, a} + {1'b0, b};
            r     = sum[31:0];
            carry = sum[32];
            ovf   = (a[31] == b[31]) && (r[31] != a[31]);
         end
         ALU_OP_SUB: begin
            sum   = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r     = sum[31:0];
            carry = sum[32];
            ovf   = (a[31] != b[31]) && (r[31] != a[31]);
         end
         ALU_OP_AND: r = a & b;
         ALU_OP_OR:  r = a | b;
         ALU_OP_XOR: r = a ^ b;
         ALU_OP_SLL: r = a << b[4:0];
         ALU_OP_SRL: r = a >> b[4:0];
         ALU_OP_SRA: r = $signed(a) >>> b[4:0];
         default:    r = a;
      endcase
   end

   assign res           = r;
   assign flags[FLAG_N] = r[31];
   assign flags[FLAG_Z] = (r == '0);
   assign flags[FLAG_C] = carry;
   assign flags[FLAG_V] = ovf;

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. One operation is in
// flight at a time: accepted in IDLE, held on the ALU for EXEC_CYCLES cycles,
// then the captured result/flags are presented to the granted requester until
// it takes them.
//   clk  in   clock, rising edge
//   rst  in   asynchronous, active-high reset
//   bus  slave modport of alu_arbiter_if (request and response channels)
// Parameters:
//   DATA_W      operand/result width, must stay 32 to match alu
//   EXEC_CYCLES cycles the operands are held before capture, 1..15
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a tie and no
//                          round-robin history is kept.
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int EXEC_CYCLES = 1
)
(
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);

   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   state_e              state_q;
   logic                grant_id_q;
   logic [3:0]          cnt_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [3:0]          op_q;
   logic [DATA_W-1:0]   res_q;
   logic [3:0]          flags_q;
   logic [NUM_REQ-1:0]  resp_valid_q;

   logic [NUM_REQ-1:0]  grant_oh;
   logic                grant_id;
   logic [DATA_W-1:0]   alu_res;
   logic [3:0]          alu_flags;

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant_oh = '0;
      if (bus.req_valid[0])
         grant_oh = 2'b01;
      else if (bus.req_valid[1])
         grant_oh = 2'b10;
   end
`else
   // Id of the requester granted most recently; resets to 1 so that
   // requester 0 wins the first tie.
   logic last_grant_q;

   always_comb begin
      grant_oh = bus.req_valid;
      if (&bus.req_valid)
         grant_oh = last_grant_q ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant_q <= 1'b1;
      else if (state_q == ST_IDLE && (|grant_oh))
         last_grant_q <= grant_id;
   end
`endif

   assign grant_id = grant_oh[1];

   // Ready is combinational in IDLE; gated by rst so it reads 0 while the
   // reset is held even though it does not come from a register.
   assign bus.req_ready = (state_q == ST_IDLE && !rst) ? grant_oh : '0;

   alu alu0 (
      .a     (a_q),
      .b     (b_q),
      .op    (op_q),
      .res   (alu_res),
      .flags (alu_flags)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_id_q   <= 1'b0;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         res_q        <= '0;
         flags_q      <= '0;
         resp_valid_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|grant_oh) begin
                  a_q        <= bus.req_a[grant_id];
                  b_q        <= bus.req_b[grant_id];
                  op_q       <= bus.req_op[grant_id];
                  grant_id_q <= grant_id;
                  cnt_q      <= CNT_LOAD;
                  state_q    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt_q == 4'd0) begin
                  res_q        <= alu_res;
                  flags_q      <= alu_flags;
                  resp_valid_q <= grant_id_q ? 2'b10 : 2'b01;
                  state_q      <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               // Only the granted requester's ready completes the response.
               if (bus.resp_ready[grant_id_q]) begin
                  resp_valid_q <= '0;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_res   = res_q;
   assign bus.resp_flags = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. Two instances: one with EXEC_CYCLES=1,
// one with EXEC_CYCLES=4. Expected responses are queued when a request is
// driven and compared when the response appears.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   alu_arbiter_if bus1();
   alu_arbiter_if bus4();

   alu_arbiter #(.DATA_W(32), .EXEC_CYCLES(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   alu_arbiter #(.DATA_W(32), .EXEC_CYCLES(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] a0;
      logic [31:0] b0;
      logic [31:0] a1;
      logic [31:0] b1;
      logic [1:0]  exp_grant;
      logic [31:0] exp_res;
      logic [3:0]  exp_flags;
   } vec_t;

   typedef struct {
      bit          d;
      logic [1:0]  oh;
      logic [31:0] res;
      logic [3:0]  flags;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[6];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] g,
                               input logic [31:0] r, input logic [3:0] f);
      vec_t x;
      x.valid = v; x.a0 = a0; x.b0 = b0; x.a1 = a1; x.b1 = b1;
      x.exp_grant = g; x.exp_res = r; x.exp_flags = f;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] get_ready(input bit d);
      if (d) return bus4.req_ready;
      return bus1.req_ready;
   endfunction

   function automatic logic [1:0] get_rvalid(input bit d);
      if (d) return bus4.resp_valid;
      return bus1.resp_valid;
   endfunction

   function automatic logic [31:0] get_res(input bit d);
      if (d) return bus4.resp_res;
      return bus1.resp_res;
   endfunction

   function automatic logic [3:0] get_flags(input bit d);
      if (d) return bus4.resp_flags;
      return bus1.resp_flags;
   endfunction

   task automatic drive(input bit d, input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1);
      if (d) begin
         bus4.req_valid = v;
         bus4.req_a[0] = a0; bus4.req_b[0] = b0;
         bus4.req_a[1] = a1; bus4.req_b[1] = b1;
      end else begin
         bus1.req_valid = v;
         bus1.req_a[0] = a0; bus1.req_b[0] = b0;
         bus1.req_a[1] = a1; bus1.req_b[1] = b1;
      end
   endtask

   task automatic check_resp(input bit d, input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_sb actual=response required=no_response", tag);
         return;
      end
      e = sb_q.pop_front();
      chk({tag, "_resp_valid"}, 32'(get_rvalid(d)), 32'(e.oh));
      chk({tag, "_res"}, get_res(d), e.res);
      chk({tag, "_flags"}, 32'(get_flags(d)), 32'(e.flags));
      $display("txn %s dut=%0d resp_valid=%b res=0x%08h flags=%b", tag, d ? 4 : 1,
               get_rvalid(d), get_res(d), get_flags(d));
   endtask

   // Waits (bounded) for resp_valid; returns the number of cycles after the
   // accept edge, or -1 on timeout. Called at the first negedge after accept.
   task automatic wait_resp(input bit d, input bit drop_valid, input string tag, output int lat);
      int n;
      lat = -1;
      for (n = 1; n <= 40; n++) begin
         if (drop_valid) drive(d, 2'b00, 0, 0, 0, 0);
         #1;
         if (get_rvalid(d) != 2'b00) begin
            lat = n - 1;
            break;
         end
         chk({tag, "_busy_ready"}, 32'(get_ready(d)), 32'(0));
         @(negedge clk);
      end
      if (lat < 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_resp required=resp_valid", tag);
         if (sb_q.size() != 0) void'(sb_q.pop_front());
      end
   endtask

   task automatic issue(input bit d, input vec_t v, input int exp_lat, input string tag);
      exp_t e;
      int   lat;
      @(negedge clk);
      drive(d, v.valid, v.a0, v.b0, v.a1, v.b1);
      #1;
      chk({tag, "_grant"}, 32'(get_ready(d)), 32'(v.exp_grant));
      e.d = d; e.oh = v.exp_grant; e.res = v.exp_res; e.flags = v.exp_flags;
      sb_q.push_back(e);
      @(negedge clk);
      wait_resp(d, 1'b1, tag, lat);
      if (lat >= 0) begin
         chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
         check_resp(d, tag);
         @(negedge clk);
         #1;
         chk({tag, "_after_hs"}, 32'(get_rvalid(d)), 32'(0));
      end
   endtask

   initial begin
      exp_t e;
      int   lat;

      tbl[0] = mk(2'b01, 32'd2, 32'd3, 32'd0, 32'd0, 2'b01, 32'd5, 4'b0000);
      tbl[1] = mk(2'b10, 32'd0, 32'd0, 32'd11, -32'sd11, 2'b10, 32'd0, 4'b0110);
`ifdef ALU_ARB_FIXED_PRIO_EN
      for (int i = 2; i < 6; i++)
         tbl[i] = mk(2'b11, 32'h7fff_fff5, 32'd11, 32'd20, -32'sd25, 2'b01, 32'h8000_0000, 4'b1001);
`else
      for (int i = 2; i < 6; i++) begin
         if (i % 2 == 0)
            tbl[i] = mk(2'b11, 32'h7fff_fff5, 32'd11, 32'd20, -32'sd25, 2'b01, 32'h8000_0000, 4'b1001);
         else
            tbl[i] = mk(2'b11, 32'h7fff_fff5, 32'd11, 32'd20, -32'sd25, 2'b10, -32'sd5, 4'b1000);
      end
`endif

      // Reset with both requesters asserting valid: nothing may be granted.
      rst = 1'b1;
      bus1.req_op = '0; bus4.req_op = '0;
      bus1.resp_ready = 2'b11; bus4.resp_ready = 2'b11;
      drive(0, 2'b11, 1, 2, 3, 4);
      drive(1, 2'b11, 1, 2, 3, 4);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(bus1.req_ready), 32'(0));
      chk("rst_resp_valid", 32'(bus1.resp_valid), 32'(0));
      chk("rst_res", bus1.resp_res, 32'd0);
      chk("rst_flags", 32'(bus1.resp_flags), 32'(0));
      chk("rst4_req_ready", 32'(bus4.req_ready), 32'(0));
      drive(0, 2'b00, 0, 0, 0, 0);
      drive(1, 2'b00, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         issue(0, tbl[i], 1, $sformatf("vec%0d", i));

      // Backpressure: response held while req_a changes and the wrong
      // requester's ready toggles; valid held high to probe req_ready.
      @(negedge clk);
      bus1.resp_ready = 2'b00;
      drive(0, 2'b11, 32'd2, 32'd3, 32'd100, 32'd1);
      #1;
      chk("bp_grant", 32'(bus1.req_ready), 32'(2'b01));
      e.d = 0; e.oh = 2'b01; e.res = 32'd5; e.flags = 4'b0000;
      sb_q.push_back(e);
      @(negedge clk);
      wait_resp(0, 1'b0, "bp", lat);
      if (lat >= 0) begin
         chk("bp_latency", 32'(lat), 32'(1));
         check_resp(0, "bp");
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus1.req_a[0] = $urandom;
            bus1.resp_ready = (i % 2 == 1) ? 2'b10 : 2'b00;
            #1;
            chk("bp_hold_res", bus1.resp_res, 32'd5);
            chk("bp_hold_flags", 32'(bus1.resp_flags), 32'(0));
            chk("bp_hold_valid", 32'(bus1.resp_valid), 32'(2'b01));
            chk("bp_hold_ready", 32'(bus1.req_ready), 32'(0));
         end
         @(negedge clk);
         drive(0, 2'b00, 0, 0, 0, 0);
         bus1.resp_ready = 2'b01;
         @(negedge clk);
         #1;
         chk("bp_release_valid", 32'(bus1.resp_valid), 32'(0));
         drive(0, 2'b01, 1, 1, 0, 0);
         #1;
         chk("bp_back_idle", 32'(bus1.req_ready), 32'(2'b01));
         drive(0, 2'b00, 0, 0, 0, 0);
         $display("txn bp dut=1 released after 10 held cycles");
      end
      bus1.resp_ready = 2'b11;

      // EXEC_CYCLES=4 latency and flags
      issue(1, mk(2'b01, -32'sd32, -32'sd7, 32'd0, 32'd0, 2'b01, -32'sd39, 4'b1010), 4, "exec4");

      // Reset during EXEC on the 4-cycle instance
      @(negedge clk);
      drive(1, 2'b01, 32'd1, 32'd1, 32'd5, 32'd5);
      #1;
      chk("rstx_grant", 32'(bus4.req_ready), 32'(2'b01));
      @(negedge clk);
      drive(1, 2'b00, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstx_resp_valid", 32'(bus4.resp_valid), 32'(0));
      chk("rstx_res", bus4.resp_res, 32'd0);
      chk("rstx_flags", 32'(bus4.resp_flags), 32'(0));
      chk("rstx_req_ready", 32'(bus4.req_ready), 32'(0));
      $display("txn rstx dut=4 reset asserted during EXEC");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         chk("rstx_no_resp", 32'(bus4.resp_valid), 32'(0));
      end
      issue(1, mk(2'b11, 32'd1, 32'd1, 32'd5, 32'd5, 2'b01, 32'd2, 4'b0000), 4, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer/arbiter sharing the single combinational 32-bit `alu` between two requesters (e.g. core execute stage and an address/auxiliary unit). Accepts one operation at a time over a valid/ready handshake and holds it in an operand register. It waits a configurable number of cycles for the ALU to settle, captures result and flags, and returns them to the granted requester over a valid/ready response channel.

## Interface
- `DATA_W`, 32, operand/result width; fixed to 32 (must match `alu`)
- `EXEC_CYCLES`, 1, cycles operands are held on the ALU before capture; legal range 1..15

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  [1:0]  request valid, one bit per requester
- `req_ready`  out  [1:0]  request accepted when `req_valid[i] & req_ready[i]` at a rising edge
- `req_a`  in  [1:0][31:0]  operand a per requester
- `req_b`  in  [1:0][31:0]  operand b per requester
- `req_op`  in  [1:0][3:0]  ALU opcode per requester (0 = add); passed through unmodified
- `resp_valid`  out  [1:0]  one-hot response valid, to the granted requester
- `resp_ready`  in  [1:0]  response consumed when `resp_valid[i] & resp_ready[i]`
- `resp_res`  out  32  captured ALU result
- `resp_flags`  out  4  captured flags, {N, Z, C, V}

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: `req_ready` is the one-hot grant (0 if no request). On handshake, latch a/b/op into operand regs, record grant id, load exec counter with `EXEC_CYCLES-1`, go EXEC.
- EXEC: operand regs drive `alu`. Counter decrements each cycle. When counter is 0, capture `res`/`flags` into response regs and go RESP.
- RESP: `resp_valid[id]`=1, `resp_res`/`resp_flags` stable. On `resp_ready[id]`, go IDLE. `resp_ready` of the non-granted requester is ignored.
- `req_ready` is 0 in EXEC and RESP. No accept occurs in the same cycle as a response handshake.
- Arbitration: round-robin over `last_grant` (reset 1, so requester 0 wins first). If both are valid, grant `~last_grant`. If one is valid, grant it. `last_grant` updates only on an accepted request.
- Requester inputs are sampled only at the accept edge. Later changes do not affect an in-flight op.
- Arithmetic and flags are entirely the `alu`'s. The arbiter adds no width extension or flag masking.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_res`=0, `resp_flags`=0, state IDLE, `last_grant`=1, operand regs 0.
- `req_ready` in IDLE is combinational from `req_valid` and `last_grant`.
- Latency: accept edge T, capture edge T+`EXEC_CYCLES`, `resp_valid` high from cycle T+`EXEC_CYCLES` onward.
- Minimum issue interval: `EXEC_CYCLES`+2 cycles with `resp_ready` held high.
- Backpressure: response held indefinitely. Outputs are unchanged while `resp_ready`=0.
- Reset mid-operation (EXEC or RESP): in-flight op dropped, no response issued, all outputs return to reset values asynchronously.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority, requester 0 always wins when both are valid. `last_grant` is not implemented.
- Undefined (default): round-robin as above.

## Structure
- Package `alu_arb_pkg`: state enum (`ST_IDLE`, `ST_EXEC`, `ST_RESP`), `NUM_REQ`=2, flag bit indices (`FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0), `ALU_OP_ADD`=4'd0.
- One sub-module: existing `alu`, instantiated once as `alu0`. Arbiter logic stays in `alu_arbiter`; no further split.

## Test plan
- Req0 only, a=2, b=3, op=0, `EXEC_CYCLES`=1 -> `resp_valid`=2'b01 one cycle after accept, res=5, flags=4'b0000.
- Req1 only, a=11, b=-11 -> `resp_valid`=2'b10, res=0, flags=4'b0110.
- Both valid for 4 consecutive ops (req0 a=0x7ffffff5, b=11; req1 a=20, b=-25) -> grant order 0,1,0,1. Req0 flags=4'b1001; req1 res=-5, flags=4'b1000. With `ALU_ARB_FIXED_PRIO_EN`, the order is 0,0,0,0.
- `EXEC_CYCLES`=4, a=-32, b=-7 -> `resp_valid` asserted exactly 4 cycles after accept, res=-39, flags=4'b1010.
- `resp_ready`=0 for 10 cycles in RESP, and req_a changed meanwhile -> res and flags unchanged, `req_ready`=0 throughout. Release gives one handshake, then IDLE.
- Assert `rst` during EXEC -> all outputs 0 immediately. No `resp_valid` after reset is released. The next request is granted to requester 0.
